inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction-fetch initiator for the instruction ROM. Owns the program counter and drives the ROM chip-enable and byte address.
- Captures the combinational ROM data, with its PC, into the IF/ID pipeline register.
- Handles pipeline stall, ID-stage branch redirect (delay slot preserved) and exception flush with new-PC load.

Parameters:
- ADDR_W, 32, width of PC / ROM byte address (`Inst_Addr)
- DATA_W, 32, instruction width (`Inst_Data)
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall_i  in  1  hold PC and IF/ID register
- branch_flag_i  in  1  ID-stage branch taken
- branch_target_i  in  ADDR_W  branch destination
- flush_i  in  1  exception flush
- new_pc_i  in  ADDR_W  exception handler address
- rom_ce_o  out  1  ROM chip enable (`Chip_Enable / `Chip_Disable)
- rom_addr_o  out  ADDR_W  ROM byte address (= pc)
- rom_inst_i  in  DATA_W  combinational ROM output
- id_pc_o  out  ADDR_W  PC of instruction in IF/ID
- id_inst_o  out  DATA_W  instruction in IF/ID
- id_valid_o  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, immediate, including mid-operation): state=S_OFF, pc=RESET_PC, rom_ce_o=0, id_pc_o=0, id_inst_o=`Zero_Word, id_valid_o=0, pending_valid=0, pending_pc=0.
- FSM states:
  - S_OFF: ce=0.
  - S_RUN: ce=1, fetching.
  - S_HOLD: ce=1, stalled.
- Transitions:
  - S_OFF -> S_RUN on the first edge after reset release. pc stays RESET_PC and nothing is captured.
  - S_RUN -> S_HOLD when stall_i=1. S_HOLD -> S_RUN when stall_i=0.
- rom_addr_o = pc (registered). Address is stable while ce=1 and stalled.
- Latency: the instruction at address A appears on id_inst_o/id_pc_o one clock after rom_addr_o=A.
- Per-edge priority in S_RUN/S_HOLD: flush_i > stall_i > branch > sequential.
  1. flush_i=1, regardless of stall: pc<=new_pc_i; id_inst<=0, id_pc<=0, id_valid<=0; pending cleared; state->S_RUN.
  2. stall_i=1: pc and IF/ID hold. If branch_flag_i=1, then pending_pc<=branch_target_i and pending_valid<=1; a later branch overwrites it.
  3. Not stalled, branch_flag_i=1: pc<=branch_target_i. The IF/ID register captures the current fetch (the delay slot) normally.
  4. Not stalled, pending_valid=1, no new branch: pc<=pending_pc, then pending cleared. The IF/ID register captures normally.
  5. Otherwise: pc<=pc+4; id_pc<=pc; id_inst<=rom_inst_i; id_valid<=1.
- In cases 3 and 4 the IF/ID register captures as in case 5.
- Arithmetic: pc+4 is modulo 2^ADDR_W (32'hFFFF_FFFC -> 0). Bits [1:0] of every loaded target (branch, pending, new_pc) are forced to 0.
- Simultaneous flush and branch: flush wins and the branch is discarded.
- Stall asserted in the cycle S_OFF->S_RUN: S_OFF still exits, and the FSM enters S_HOLD on the following edge if the stall persists.

Decomposition:
- Shared define.v: existing `Chip_Enable, `Chip_Disable, `Zero_Word, `Inst_Addr, `Inst_Data.
- New in define.v: `PC_Step (4), and state encodings `IF_S_OFF, `IF_S_RUN, `IF_S_HOLD (2 bits).
- One natural sub-module: if_id_reg (IF/ID pipeline register with hold/flush/valid). The PC and FSM stay in inst_fetch.

Test Plan:
- Reset release with ROM preloaded 0x11,0x22,0x33 at 0,4,8 -> rom_ce_o rises 1 clk after release; id_inst 0x11/0x22/0x33 with id_pc 0/4/8 on consecutive clocks; id_valid=1 from the first capture.
- stall_i high 3 clks while rom_addr_o=0x8 -> rom_addr_o stays 0x8, id_pc_o/id_inst_o frozen; the sequence resumes 0xC after release with no skipped or duplicated instruction.
- branch_flag_i with target 0x100 while pc=0x10 -> the instruction at 0x10 (delay slot) is captured; the next rom_addr_o is 0x100.
- Branch target 0x200 asserted during a 2-clk stall -> pc holds; the first unstalled edge loads 0x200; pending_valid cleared.
- flush_i with new_pc_i 0x180 coincident with stall_i and branch_flag_i -> pc=0x180, id_valid_o=0, id_inst_o=0, pending cleared.
- pc=32'hFFFF_FFFC, no events -> next rom_addr_o=0. Assert rst_n=0 mid-stall -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch stage.
// Holds chip-enable levels, the sequential PC step and the fetch FSM state type.
package inst_fetch_pkg;

  localparam logic        CHIP_ENABLE  = 1'b1;
  localparam logic        CHIP_DISABLE = 1'b0;
  localparam int unsigned PC_STEP      = 4;

  typedef enum logic [1:0] {
    IF_S_OFF  = 2'd0,
    IF_S_RUN  = 2'd1,
    IF_S_HOLD = 2'd2
  } if_state_e;

endpackage

// File: rtl/inst_fetch_if_id_reg.sv
// IF/ID pipeline register: captures a fetched instruction with its PC.
// Clear wins over capture; with neither asserted the contents hold.
module if_id_reg
  import inst_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture_i,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [DATA_W-1:0] inst_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [DATA_W-1:0] id_inst_o,
  output logic              id_valid_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_pc_o    <= '0;
      id_inst_o  <= '0;
      id_valid_o <= 1'b0;
    end else if (clear_i) begin
      id_pc_o    <= '0;
      id_inst_o  <= '0;
      id_valid_o <= 1'b0;
    end else if (capture_i) begin
      id_pc_o    <= pc_i;
      id_inst_o  <= inst_i;
      id_valid_o <= 1'b1;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch initiator: owns the PC, drives the ROM and fills IF/ID.
// Handles stall, ID-stage branch redirect (delay slot kept) and exception flush.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_inst_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [DATA_W-1:0] id_inst_o,
  output logic              id_valid_o,
  output logic [1:0]        dbg_state_o
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic              capture, clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IF_S_OFF;
      pc_q         <= RESET_PC;
      pend_pc_q    <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  // Priority per edge while active: flush > stall > branch > pending > sequential.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    capture      = 1'b0;
    clear        = 1'b0;
    unique case (state_q)
      IF_S_OFF: state_d = IF_S_RUN;
      IF_S_RUN, IF_S_HOLD: begin
        if (flush_i) begin
          state_d      = IF_S_RUN;
          pc_d         = new_pc_i & ALIGN_MASK;
          pend_pc_d    = '0;
          pend_valid_d = 1'b0;
          clear        = 1'b1;
        end else if (stall_i) begin
          state_d = IF_S_HOLD;
          if (branch_flag_i) begin
            pend_pc_d    = branch_target_i & ALIGN_MASK;
            pend_valid_d = 1'b1;
          end
        end else begin
          state_d = IF_S_RUN;
          capture = 1'b1;
          if (branch_flag_i) begin
            // A fresh branch supersedes any redirect remembered during a stall.
            pc_d         = branch_target_i & ALIGN_MASK;
            pend_valid_d = 1'b0;
          end else if (pend_valid_q) begin
            pc_d         = pend_pc_q;
            pend_valid_d = 1'b0;
          end else begin
            pc_d = pc_q + ADDR_W'(PC_STEP);
          end
        end
      end
      default: state_d = IF_S_OFF;
    endcase
  end

  assign rom_ce_o    = (state_q == IF_S_OFF) ? CHIP_DISABLE : CHIP_ENABLE;
  assign rom_addr_o  = pc_q;
  assign dbg_state_o = state_q;

  // id_valid_o qualifies id_pc_o/id_inst_o: when low the IF/ID slot is a bubble.
  if_id_reg #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_if_id_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture_i (capture),
    .clear_i   (clear),
    .pc_i      (pc_q),
    .inst_i    (rom_inst_i),
    .id_pc_o   (id_pc_o),
    .id_inst_o (id_inst_o),
    .id_valid_o(id_valid_o)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: ROM model, scoreboard of expected
// IF/ID captures, one task per scenario, summary line at the end.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] new_pc_i = '0;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;
  logic [1:0]  dbg_state_o;

  int checks = 0;
  int failures = 0;

  logic [63:0] exp_q[$];
  logic [63:0] exp_v;

  // Reference state: 0 off, 1 run, 2 hold
  int          m_state;
  logic [31:0] m_pc;
  logic [31:0] m_ppc;
  logic        m_pv;
  logic        m_cap;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall_i),
    .branch_flag_i  (branch_flag_i),
    .branch_target_i(branch_target_i),
    .flush_i        (flush_i),
    .new_pc_i       (new_pc_i),
    .rom_ce_o       (rom_ce_o),
    .rom_addr_o     (rom_addr_o),
    .rom_inst_i     (rom_inst_i),
    .id_pc_o        (id_pc_o),
    .id_inst_o      (id_inst_o),
    .id_valid_o     (id_valid_o),
    .dbg_state_o    (dbg_state_o)
  );

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0011;
      32'h4:   return 32'h0000_0022;
      32'h8:   return 32'h0000_0033;
      default: return 32'hC0DE_0000 ^ a;
    endcase
  endfunction

  assign rom_inst_i = rom_fn(rom_addr_o);

  task automatic model_reset();
    m_state = 0;
    m_pc    = 32'h0;
    m_ppc   = 32'h0;
    m_pv    = 1'b0;
    m_cap   = 1'b0;
    exp_q.delete();
  endtask

  // Drive one cycle of stimulus, advance the reference model, push expected capture.
  task automatic cyc(input logic st, input logic br, input logic [31:0] tgt,
                     input logic fl, input logic [31:0] npc);
    stall_i         = st;
    branch_flag_i   = br;
    branch_target_i = tgt;
    flush_i         = fl;
    new_pc_i        = npc;
    m_cap           = 1'b0;
    if (m_state == 0) begin
      m_state = 1;
    end else if (fl) begin
      m_state = 1;
      m_pc    = npc & 32'hFFFF_FFFC;
      m_pv    = 1'b0;
      m_ppc   = 32'h0;
    end else if (st) begin
      m_state = 2;
      if (br) begin
        m_ppc = tgt & 32'hFFFF_FFFC;
        m_pv  = 1'b1;
      end
    end else begin
      m_state = 1;
      m_cap   = 1'b1;
      exp_q.push_back({m_pc, rom_fn(m_pc)});
      if (br) begin
        m_pc = tgt & 32'hFFFF_FFFC;
        m_pv = 1'b0;
      end else if (m_pv) begin
        m_pc = m_ppc;
        m_pv = 1'b0;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    stall_i = 0; branch_flag_i = 0; flush_i = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rom_ce_o !== 1'b0) begin failures++; $display("FAIL reset_ce got=%b exp=0", rom_ce_o); end
    checks++; if (rom_addr_o !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", rom_addr_o); end
    checks++; if ({id_pc_o, id_inst_o, id_valid_o} !== 65'h0) begin failures++; $display("FAIL reset_ifid got=%h/%h/%b exp=0/0/0", id_pc_o, id_inst_o, id_valid_o); end
    checks++; if (dbg_state_o !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state_o); end
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0);
    checks++; if (rom_ce_o !== 1'b1 || dbg_state_o !== 2'd1) begin failures++; $display("FAIL first_edge_ce got=%b/%0d exp=1/1", rom_ce_o, dbg_state_o); end
    checks++; if (rom_addr_o !== 32'h0 || id_valid_o !== 1'b0) begin failures++; $display("FAIL first_edge_nocap got=%h/%b exp=0/0", rom_addr_o, id_valid_o); end
  endtask

  task automatic test_sequence();
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 0, 0);
      if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL seq_queue_empty got=0 exp=1"); end
      else begin
        exp_v = exp_q.pop_front();
        checks++; if ({id_pc_o, id_inst_o} !== exp_v || id_valid_o !== 1'b1) begin failures++; $display("FAIL seq_capture got=%h/%h/%b exp=%h/1", id_pc_o, id_inst_o, id_valid_o, exp_v); end
      end
    end
    checks++; if (id_pc_o !== 32'h4 || id_inst_o !== 32'h22) begin failures++; $display("FAIL seq_second got=%h/%h exp=4/22", id_pc_o, id_inst_o); end
    checks++; if (rom_addr_o !== 32'h8) begin failures++; $display("FAIL seq_addr got=%h exp=8", rom_addr_o); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0);
      checks++; if (rom_addr_o !== 32'h8 || id_pc_o !== 32'h4 || id_inst_o !== 32'h22 || dbg_state_o !== 2'd2) begin
        failures++; $display("FAIL stall_hold got=%h/%h/%h/%0d exp=8/4/22/2", rom_addr_o, id_pc_o, id_inst_o, dbg_state_o);
      end
    end
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 0, 0);
      exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hX;
      checks++; if ({id_pc_o, id_inst_o} !== exp_v || id_valid_o !== 1'b1) begin failures++; $display("FAIL stall_resume got=%h/%h exp=%h", id_pc_o, id_inst_o, exp_v); end
    end
    checks++; if (id_pc_o !== 32'hC || rom_addr_o !== 32'h10) begin failures++; $display("FAIL stall_after got=%h/%h exp=c/10", id_pc_o, rom_addr_o); end
  endtask

  task automatic test_branch();
    cyc(0, 1, 32'h100, 0, 0);
    exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hX;
    checks++; if ({id_pc_o, id_inst_o} !== exp_v || id_pc_o !== 32'h10) begin failures++; $display("FAIL branch_delay_slot got=%h/%h exp=%h", id_pc_o, id_inst_o, exp_v); end
    checks++; if (rom_addr_o !== 32'h100) begin failures++; $display("FAIL branch_target got=%h exp=100", rom_addr_o); end
    cyc(0, 0, 0, 0, 0);
    exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hX;
    checks++; if ({id_pc_o, id_inst_o} !== exp_v || rom_addr_o !== 32'h104) begin failures++; $display("FAIL branch_follow got=%h/%h/%h exp=%h/104", id_pc_o, id_inst_o, rom_addr_o, exp_v); end
  endtask

  task automatic test_pending();
    cyc(1, 1, 32'h200, 0, 0);
    cyc(1, 0, 0, 0, 0);
    checks++; if (rom_addr_o !== 32'h104 || id_pc_o !== 32'h100) begin failures++; $display("FAIL pend_hold got=%h/%h exp=104/100", rom_addr_o, id_pc_o); end
    cyc(0, 0, 0, 0, 0);
    exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hX;
    checks++; if ({id_pc_o, id_inst_o} !== exp_v) begin failures++; $display("FAIL pend_capture got=%h/%h exp=%h", id_pc_o, id_inst_o, exp_v); end
    checks++; if (rom_addr_o !== 32'h200) begin failures++; $display("FAIL pend_load got=%h exp=200", rom_addr_o); end
    cyc(0, 0, 0, 0, 0);
    void'(exp_q.pop_front());
    checks++; if (rom_addr_o !== 32'h204) begin failures++; $display("FAIL pend_cleared got=%h exp=204", rom_addr_o); end
    // later stalled branch overwrites an earlier one; low bits are dropped
    cyc(1, 1, 32'h400, 0, 0);
    cyc(1, 1, 32'h302, 0, 0);
    cyc(0, 0, 0, 0, 0);
    exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hX;
    checks++; if ({id_pc_o, id_inst_o} !== exp_v || rom_addr_o !== 32'h300) begin failures++; $display("FAIL pend_overwrite got=%h/%h exp=300 cap=%h", rom_addr_o, id_pc_o, exp_v); end
  endtask

  task automatic test_flush();
    cyc(1, 1, 32'h600, 0, 0);
    cyc(1, 1, 32'h500, 1, 32'h181);
    checks++; if (rom_addr_o !== 32'h180 || dbg_state_o !== 2'd1) begin failures++; $display("FAIL flush_pc got=%h/%0d exp=180/1", rom_addr_o, dbg_state_o); end
    checks++; if ({id_pc_o, id_inst_o, id_valid_o} !== 65'h0) begin failures++; $display("FAIL flush_bubble got=%h/%h/%b exp=0/0/0", id_pc_o, id_inst_o, id_valid_o); end
    cyc(0, 0, 0, 0, 0);
    exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hX;
    checks++; if ({id_pc_o, id_inst_o} !== exp_v || id_valid_o !== 1'b1) begin failures++; $display("FAIL flush_resume got=%h/%h exp=%h", id_pc_o, id_inst_o, exp_v); end
    checks++; if (rom_addr_o !== 32'h184) begin failures++; $display("FAIL flush_pend_cleared got=%h exp=184", rom_addr_o); end
  endtask

  task automatic test_wrap();
    cyc(0, 0, 0, 1, 32'hFFFF_FFFC);
    checks++; if (rom_addr_o !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_load got=%h exp=fffffffc", rom_addr_o); end
    cyc(0, 0, 0, 0, 0);
    exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hX;
    checks++; if ({id_pc_o, id_inst_o} !== exp_v) begin failures++; $display("FAIL wrap_capture got=%h/%h exp=%h", id_pc_o, id_inst_o, exp_v); end
    checks++; if (rom_addr_o !== 32'h0) begin failures++; $display("FAIL wrap_addr got=%h exp=0", rom_addr_o); end
  endtask

  task automatic test_async_reset();
    cyc(1, 1, 32'h700, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rom_ce_o !== 1'b0 || rom_addr_o !== 32'h0 || dbg_state_o !== 2'd0) begin failures++; $display("FAIL async_rst_fetch got=%b/%h/%0d exp=0/0/0", rom_ce_o, rom_addr_o, dbg_state_o); end
    checks++; if ({id_pc_o, id_inst_o, id_valid_o} !== 65'h0) begin failures++; $display("FAIL async_rst_ifid got=%h/%h/%b exp=0/0/0", id_pc_o, id_inst_o, id_valid_o); end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // stall present on the OFF exit edge: still leaves OFF, then holds
    cyc(1, 0, 0, 0, 0);
    checks++; if (dbg_state_o !== 2'd1 || rom_ce_o !== 1'b1) begin failures++; $display("FAIL stall_off_exit got=%0d/%b exp=1/1", dbg_state_o, rom_ce_o); end
    cyc(1, 0, 0, 0, 0);
    checks++; if (dbg_state_o !== 2'd2 || rom_addr_o !== 32'h0 || id_valid_o !== 1'b0) begin failures++; $display("FAIL stall_off_hold got=%0d/%h/%b exp=2/0/0", dbg_state_o, rom_addr_o, id_valid_o); end
    cyc(0, 0, 0, 0, 0);
    exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hX;
    checks++; if ({id_pc_o, id_inst_o} !== exp_v || id_inst_o !== 32'h11 || rom_addr_o !== 32'h4) begin failures++; $display("FAIL restart_capture got=%h/%h/%h exp=%h/4", id_pc_o, id_inst_o, rom_addr_o, exp_v); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_stall();
    test_branch();
    test_pending();
    test_flush();
    test_wrap();
    test_async_reset();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL queue_drained got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
